// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, data-memory
// freeze with bounded wait/halt, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_wr_reg,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic             halted_reg, halted_next;
  logic             mem_busy, load_use, freeze;
  logic             branch_flush;
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign mem_busy = dmem_req & ~dmem_ready;
  assign load_use = ex_mem_to_reg & ex_reg_write & (ex_wr_reg != 5'd0) &
                    ((ex_wr_reg == id_rs) | (id_uses_rt & (ex_wr_reg == id_rt)));
  assign freeze   = mem_busy | (state_reg == HALT);

  // Priority: reset, freeze, taken branch, load-use, normal flow.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    branch_flush = 1'b0;
    if (reset || freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_next = RUN;
        end else if (wait_cnt_reg == WCW'(TIMEOUT - 1)) begin
          state_next = HALT;
        end else begin
          wait_cnt_next = wait_cnt_reg + WCW'(1);
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
    halted_next = halted_reg | (state_next == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      halted_reg   <= halted_next;
    end
  end

  // Stall cycles exclude HALT; a held branch across a freeze counts once.
  assign cnt_inc[0] = ~pc_en & (state_reg != HALT) & ~reset;
  assign cnt_inc[1] = branch_flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (perf_clr) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign state        = state_reg;
  assign halted       = halted_reg;
  assign stall_cycles = cnt_reg[0];
  assign flush_count  = cnt_reg[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4): driver pushes
// hand-computed expectations per cycle, monitor pops and compares at negedge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_wr_reg = '0;
  logic       id_uses_rt = 0, ex_mem_to_reg = 0, ex_reg_write = 0;
  logic       branch_taken = 0, dmem_req = 0, dmem_ready = 0, perf_clr = 0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted;
  logic [1:0] state;
  logic [3:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted),
    .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // ctrl bit order: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
  localparam logic [5:0] NRM = 6'b111100;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] LU  = 6'b001101;
  localparam logic [5:0] BRF = 6'b111111;

  typedef struct packed {
    logic [5:0] ctrl;
    logic [1:0] st;
    logic       halt;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic mtr, input logic rw, input logic [4:0] wr,
                     input logic br, input logic rq, input logic rd, input logic cl,
                     input logic [5:0] ec, input logic [1:0] es,
                     input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    ex_mem_to_reg = mtr; ex_reg_write = rw; ex_wr_reg = wr;
    branch_taken = br; dmem_req = rq; dmem_ready = rd; perf_clr = cl;
    e.ctrl = ec; e.st = es; e.halt = (es == 2'd2); e.sc = esc; e.fc = efc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a.ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush};
      a.st = state; a.halt = halted; a.sc = stall_cycles; a.fc = flush_count;
      checks++;
      txn++;
      if (a !== e) begin
        failures++;
        $display("FAIL txn%0d ctrl/st/halt/sc/fc got %b/%0d/%b/%0d/%0d want %b/%0d/%b/%0d/%0d",
                 txn, a.ctrl, a.st, a.halt, a.sc, a.fc, e.ctrl, e.st, e.halt, e.sc, e.fc);
      end else begin
        $display("txn%0d ok ctrl=%b st=%0d halt=%b sc=%0d fc=%0d",
                 txn, a.ctrl, a.st, a.halt, a.sc, a.fc);
      end
    end
  end

  initial begin
    #2 reset = 1'b1;
    // reset state
    cyc(1, 0,0,0, 0,0,0, 0,0,0,0, FRZ,0,0,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,0,0);
    // load-use on rs, then load-use with $zero destination
    cyc(0, 8,0,0, 1,1,8, 0,0,0,0, LU ,0,0,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,1,0);
    cyc(0, 0,0,0, 1,1,0, 0,0,0,0, NRM,0,1,0);
    // rt match gated by id_uses_rt
    cyc(0, 1,9,0, 1,1,9, 0,0,0,0, NRM,0,1,0);
    cyc(0, 1,9,1, 1,1,9, 0,0,0,0, LU ,0,1,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,2,0);
    // branch overrides load-use
    cyc(0, 8,0,0, 1,1,8, 1,0,0,0, BRF,0,2,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,2,1);
    // load without reg_write: no stall
    cyc(0, 8,0,0, 1,0,8, 0,0,0,0, NRM,0,2,1);
    // memory wait: 3 busy cycles then ready
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,0,2,1);
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,1,3,1);
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,1,4,1);
    cyc(0, 0,0,0, 0,0,0, 0,1,1,0, NRM,1,5,1);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,5,1);
    // branch held across a freeze flushes once
    cyc(0, 0,0,0, 0,0,0, 1,1,0,0, FRZ,0,5,1);
    cyc(0, 0,0,0, 0,0,0, 1,1,1,0, BRF,1,6,1);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,6,2);
    // dmem_req dropping in MEM_WAIT returns to RUN
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,0,6,2);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,1,7,2);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,7,2);
    // load-use held across a freeze
    cyc(0, 8,0,0, 1,1,8, 0,1,0,0, FRZ,0,7,2);
    cyc(0, 8,0,0, 1,1,8, 0,1,1,0, LU ,1,8,2);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,9,2);
    // perf_clr beats a stall increment
    cyc(0, 8,0,0, 1,1,8, 0,0,0,1, LU ,0,9,2);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,0,0);
    // saturation at 15
    for (int i = 0; i < 20; i++)
      cyc(0, 8,0,0, 1,1,8, 0,0,0,0, LU, 0, (i > 15) ? 4'd15 : 4'(i), 0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,15,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,1, NRM,0,15,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,0,0);
    // timeout -> HALT after 4th busy edge
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,0,0,0);
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,1,1,0);
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,1,2,0);
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,1,3,0);
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,2,4,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, FRZ,2,4,0);
    cyc(0, 0,0,0, 0,0,0, 1,0,0,0, FRZ,2,4,0);
    // reset out of HALT
    cyc(1, 0,0,0, 0,0,0, 0,0,0,0, FRZ,0,0,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,0,0);
    // reset mid-MEM_WAIT
    cyc(0, 0,0,0, 0,0,0, 0,1,0,0, FRZ,0,0,0);
    cyc(1, 0,0,0, 0,0,0, 0,1,0,0, FRZ,0,0,0);
    cyc(0, 0,0,0, 0,0,0, 0,0,0,0, NRM,0,0,0);
    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
